// File: rtl/dmem_pkg.sv
// Shared opcodes, funct3 codes and FSM state type for the data-memory responder.
package dmem_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// EX/MEM request and MEM/WB response bundle between the pipeline and the responder.
interface dmem_responder_if;

   logic        req_valid;
   logic [6:0]  req_op;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        fault;

   // Pipeline side: issues requests, observes stall and response.
   modport master (
      output req_valid, req_op, req_funct3, req_addr, req_wdata,
      input  req_ready, stall, resp_valid, resp_rdata, fault
   );

   // Responder side.
   modport slave (
      input  req_valid, req_op, req_funct3, req_addr, req_wdata,
      output req_ready, stall, resp_valid, resp_rdata, fault
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores: store byte enables / replicated
// lane data, load extraction with sign/zero extension, misalignment flag.
// Optional macro DMEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses
// instead of silently clearing the offending low address bits.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic [31:0] rdata,
   output logic        misaligned
);

   logic [1:0]  a;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Effective lane offset and misalignment detection.
   always_comb begin
      a          = addr_lo;
      misaligned = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      case (funct3)
         F3_H, F3_HU: misaligned = addr_lo[0];
         F3_W:        misaligned = |addr_lo;
         default:     misaligned = 1'b0;
      endcase
`else
      case (funct3)
         F3_H, F3_HU: a = {addr_lo[1], 1'b0};
         F3_W:        a = 2'b00;
         default:     a = addr_lo;
      endcase
`endif
   end

   // Store byte enables and lane-replicated write data.
   always_comb begin
      be    = 4'b0000;
      wlane = '0;
      case (funct3)
         F3_B: begin
            be    = 4'b0001 << a;
            wlane = {4{wdata[7:0]}};
         end
         F3_H: begin
            be    = a[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata[15:0]}};
         end
         F3_W: begin
            be    = 4'b1111;
            wlane = wdata;
         end
         default: begin
            be    = 4'b0000;
            wlane = '0;
         end
      endcase
   end

   // Load lane extraction and extension.
   always_comb begin
      rbyte = rword[{a, 3'b000} +: 8];
      rhalf = a[1] ? rword[31:16] : rword[15:0];
      case (funct3)
         F3_B:    rdata = {{24{rbyte[7]}}, rbyte};
         F3_BU:   rdata = {24'h0, rbyte};
         F3_H:    rdata = {{16{rhalf[15]}}, rhalf};
         F3_HU:   rdata = {16'h0, rhalf};
         F3_W:    rdata = rword;
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder behind the EX/MEM register: latches a load/store,
// holds the pipeline for WAIT_CYCLES extra cycles, performs the access on a
// word-addressed RAM and pulses resp_valid for one cycle.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed
// and reported on fault; otherwise fault is tied low.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   dmem_responder_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   state_t              state;
   logic [3:0]          cnt;
   logic                is_load_q;
   logic                is_store_q;
   logic [2:0]          f3_q;
   logic [IDX_W+1:0]    addr_q;
   logic [31:0]         wdata_q;

   logic                ready_q;
   logic                resp_valid_q;
   logic [31:0]         resp_rdata_q;
   logic                fault_q;

   logic [31:0]         mem [DEPTH_WORDS];

   logic                is_load_in;
   logic                is_store_in;
   logic                mem_req;
   logic [IDX_W-1:0]    word_idx;
   logic [31:0]         rword;
   logic [3:0]          be;
   logic [31:0]         wlane;
   logic [31:0]         rdata_ext;
   logic                misaligned;
   logic                wr_en;

   // Request decode and RAM word addressing (upper address bits wrap).
   always_comb begin
      is_load_in  = (bus.req_op == OPC_LOAD);
      is_store_in = (bus.req_op == OPC_STORE);
      mem_req     = bus.req_valid & (is_load_in | is_store_in);
      word_idx    = addr_q[IDX_W+1:2];
      rword       = mem[word_idx];
      wr_en       = (state == ACCESS) & is_store_q & ~misaligned;
   end

   dmem_lane_align u_align (
      .funct3     (f3_q),
      .addr_lo    (addr_q[1:0]),
      .wdata      (wdata_q),
      .rword      (rword),
      .be         (be),
      .wlane      (wlane),
      .rdata      (rdata_ext),
      .misaligned (misaligned)
   );

   // Request sequencing FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         is_load_q    <= 1'b0;
         is_store_q   <= 1'b0;
         f3_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         fault_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req) begin
                  is_load_q  <= is_load_in;
                  is_store_q <= is_store_in;
                  f3_q       <= bus.req_funct3;
                  addr_q     <= bus.req_addr[IDX_W+1:0];
                  wdata_q    <= bus.req_wdata;
                  cnt        <= 4'(WAIT_CYCLES);
                  ready_q    <= 1'b0;
                  state      <= (WAIT_CYCLES > 0) ? BUSY : ACCESS;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= ACCESS;
            end
            ACCESS: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= (is_load_q & ~misaligned) ? rdata_ext : '0;
               fault_q      <= misaligned;
               state        <= RESP;
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               resp_rdata_q <= '0;
               fault_q      <= 1'b0;
               ready_q      <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Byte-enabled RAM write on the edge leaving ACCESS; contents are not reset.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (wr_en && be[i]) mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
   end

   // Output drive; stall holds upstream stages until the RESP cycle.
   always_comb begin
      bus.req_ready  = ready_q;
      bus.stall      = ((state == IDLE) & mem_req) | (state == BUSY) | (state == ACCESS);
      bus.resp_valid = resp_valid_q;
      bus.resp_rdata = resp_rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
      bus.fault      = fault_q;
`else
      bus.fault      = 1'b0;
`endif
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: WAIT_CYCLES=2 and WAIT_CYCLES=0 responders.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_responder_if a_if ();
   dmem_responder_if b_if ();

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if.slave)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if.slave)
   );

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] OPC_ALU = 7'b0110011;

   // One transaction on dut_a; lat = cycle index of resp_valid (-1 on timeout).
   task automatic acc_a(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output logic [15:0] sh);
      @(posedge clk); #1;
      a_if.req_valid = 1'b1; a_if.req_op = op; a_if.req_funct3 = f3;
      a_if.req_addr = addr; a_if.req_wdata = wd;
      lat = -1; sh = '0; rd = 'x; flt = 1'bx;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         sh[c] = a_if.stall;
         if (a_if.resp_valid) begin
            lat = c; rd = a_if.resp_rdata; flt = a_if.fault;
            break;
         end
      end
      @(posedge clk); #1;
      a_if.req_valid = 1'b0;
   endtask

   task automatic acc_b(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output logic [15:0] sh);
      @(posedge clk); #1;
      b_if.req_valid = 1'b1; b_if.req_op = op; b_if.req_funct3 = f3;
      b_if.req_addr = addr; b_if.req_wdata = wd;
      lat = -1; sh = '0; rd = 'x; flt = 1'bx;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         sh[c] = b_if.stall;
         if (b_if.resp_valid) begin
            lat = c; rd = b_if.resp_rdata; flt = b_if.fault;
            break;
         end
      end
      @(posedge clk); #1;
      b_if.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      a_if.req_valid = 1'b0; a_if.req_op = '0; a_if.req_funct3 = '0;
      a_if.req_addr = '0; a_if.req_wdata = '0;
      b_if.req_valid = 1'b0; b_if.req_op = '0; b_if.req_funct3 = '0;
      b_if.req_addr = '0; b_if.req_wdata = '0;
      rst_n = 1'b0;
      #12;
      total++;
      if ({a_if.req_ready, a_if.resp_valid, a_if.fault, a_if.stall} !== 4'b1000) begin
         bad++; $display("FAIL reset_a_ctrl got=%b exp=1000",
                         {a_if.req_ready, a_if.resp_valid, a_if.fault, a_if.stall});
      end
      total++;
      if (a_if.resp_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_a_rdata got=%h exp=00000000", a_if.resp_rdata);
      end
      total++;
      if ({b_if.req_ready, b_if.resp_valid, b_if.fault, b_if.stall} !== 4'b1000) begin
         bad++; $display("FAIL reset_b_ctrl got=%b exp=1000",
                         {b_if.req_ready, b_if.resp_valid, b_if.fault, b_if.stall});
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_sw_timing();
      logic [31:0] rd; logic flt; int lat; logic [15:0] sh;
      acc_a(OPC_STORE, F3_W, 32'h10, 32'hDEADBEEF, rd, flt, lat, sh);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL sw_latency got=%0d exp=4", lat); end
      total++;
      if (sh[4:0] !== 5'b01111) begin bad++; $display("FAIL sw_stall got=%b exp=01111", sh[4:0]); end
      total++;
      if (rd !== 32'h0 || flt !== 1'b0) begin
         bad++; $display("FAIL sw_resp got=%h/%b exp=00000000/0", rd, flt);
      end
      acc_a(OPC_LOAD, F3_W, 32'h10, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_10 got=%h exp=deadbeef", rd); end
      total++;
      if (lat !== 4) begin bad++; $display("FAIL lw_latency got=%0d exp=4", lat); end
   endtask

   task automatic test_load_ext();
      logic [31:0] rd; logic flt; int lat; logic [15:0] sh;
      acc_a(OPC_LOAD, F3_B, 32'h13, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'hFFFFFFDE) begin bad++; $display("FAIL lb_13 got=%h exp=ffffffde", rd); end
      acc_a(OPC_LOAD, F3_BU, 32'h13, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'h000000DE) begin bad++; $display("FAIL lbu_13 got=%h exp=000000de", rd); end
      acc_a(OPC_LOAD, F3_H, 32'h12, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'hFFFFDEAD) begin bad++; $display("FAIL lh_12 got=%h exp=ffffdead", rd); end
      acc_a(OPC_LOAD, F3_HU, 32'h10, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_10 got=%h exp=0000beef", rd); end
      acc_a(OPC_LOAD, 3'b011, 32'h10, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'h0 || lat !== 4) begin
         bad++; $display("FAIL load_f3_011 got=%h lat=%0d exp=00000000 lat=4", rd, lat);
      end
   endtask

   task automatic test_partial_store();
      logic [31:0] rd; logic flt; int lat; logic [15:0] sh;
      acc_a(OPC_STORE, F3_B, 32'h11, 32'h00000055, rd, flt, lat, sh);
      acc_a(OPC_LOAD, F3_W, 32'h10, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_11 got=%h exp=dead55ef", rd); end
      acc_a(OPC_STORE, F3_H, 32'h12, 32'h00001234, rd, flt, lat, sh);
      acc_a(OPC_LOAD, F3_W, 32'h10, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'h123455EF) begin bad++; $display("FAIL sh_12 got=%h exp=123455ef", rd); end
      acc_a(OPC_STORE, 3'b011, 32'h10, 32'hFFFFFFFF, rd, flt, lat, sh);
      acc_a(OPC_LOAD, F3_W, 32'h10, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'h123455EF) begin bad++; $display("FAIL store_f3_011 got=%h exp=123455ef", rd); end
   endtask

   task automatic test_wait0_wrap();
      logic [31:0] rd; logic flt; int lat; logic [15:0] sh;
      acc_b(OPC_STORE, F3_W, 32'h1000, 32'hA5A5A5A5, rd, flt, lat, sh);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL w0_latency got=%0d exp=2", lat); end
      total++;
      if (sh[2:0] !== 3'b011) begin bad++; $display("FAIL w0_stall got=%b exp=011", sh[2:0]); end
      acc_b(OPC_LOAD, F3_W, 32'h0, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL w0_wrap got=%h exp=a5a5a5a5", rd); end
   endtask

   task automatic test_non_mem();
      @(posedge clk); #1;
      b_if.req_valid = 1'b1; b_if.req_op = OPC_ALU; b_if.req_funct3 = 3'b000;
      b_if.req_addr = 32'h40; b_if.req_wdata = 32'h0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if ({b_if.stall, b_if.resp_valid, b_if.req_ready} !== 3'b001) begin
            bad++; $display("FAIL non_mem c=%0d got=%b exp=001", c,
                            {b_if.stall, b_if.resp_valid, b_if.req_ready});
         end
      end
      @(posedge clk); #1;
      b_if.req_valid = 1'b0;
   endtask

   task automatic test_reset_busy();
      logic [31:0] rd; logic flt; int lat; logic [15:0] sh;
      int seen;
      acc_a(OPC_STORE, F3_W, 32'h20, 32'h0, rd, flt, lat, sh);
      @(posedge clk); #1;
      a_if.req_valid = 1'b1; a_if.req_op = OPC_STORE; a_if.req_funct3 = F3_W;
      a_if.req_addr = 32'h20; a_if.req_wdata = 32'h1;
      @(posedge clk); #1;
      a_if.req_valid = 1'b0;
      total++;
      if (a_if.stall !== 1'b1) begin bad++; $display("FAIL rb_busy got=%b exp=1", a_if.stall); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({a_if.req_ready, a_if.stall, a_if.resp_valid, a_if.fault} !== 4'b1000) begin
         bad++; $display("FAIL rb_outputs got=%b exp=1000",
                         {a_if.req_ready, a_if.stall, a_if.resp_valid, a_if.fault});
      end
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (a_if.resp_valid) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL rb_no_resp got=%0d exp=0", seen); end
      acc_a(OPC_LOAD, F3_W, 32'h20, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL rb_discard got=%h exp=00000000", rd); end
   endtask

   task automatic test_misalign();
      logic [31:0] rd; logic flt; int lat; logic [15:0] sh;
      logic        exp_flt;
      logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_TRAP_EN
      exp_flt = 1'b1; exp_word = 32'h11111111;
`else
      exp_flt = 1'b0; exp_word = 32'h22222222;
`endif
      acc_a(OPC_STORE, F3_W, 32'h20, 32'h11111111, rd, flt, lat, sh);
      acc_a(OPC_STORE, F3_W, 32'h22, 32'h22222222, rd, flt, lat, sh);
      total++;
      if (flt !== exp_flt || lat !== 4) begin
         bad++; $display("FAIL mis_fault got=%b lat=%0d exp=%b lat=4", flt, lat, exp_flt);
      end
      acc_a(OPC_LOAD, F3_W, 32'h20, 32'h0, rd, flt, lat, sh);
      total++;
      if (rd !== exp_word) begin bad++; $display("FAIL mis_mem got=%h exp=%h", rd, exp_word); end
      total++;
      if (flt !== 1'b0) begin bad++; $display("FAIL mis_aligned_fault got=%b exp=0", flt); end
   endtask

   initial begin
      test_reset();
      test_sw_timing();
      test_load_ext();
      test_partial_store();
      test_wait0_wrap();
      test_non_mem();
      test_reset_busy();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
